// File: rtl/enemy_fleet_ctrl.sv
// Invader formation controller: owns the 10x6 alive grid, serialises kill
// requests and sequences the march (steps, edge descents, speed-up, landing).
module enemy_fleet_ctrl #(
    parameter int X_INIT     = 64,
    parameter int Y_INIT     = 48,
    parameter int STEP_X     = 4,
    parameter int STEP_Y     = 16,
    parameter int COL_PITCH  = 32,
    parameter int ROW_PITCH  = 24,
    parameter int ENEMY_W    = 24,
    parameter int ENEMY_H    = 16,
    parameter int X_MIN      = 8,
    parameter int X_MAX      = 631,
    parameter int Y_LAND     = 440,
    parameter int PERIOD_MIN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             game_start,
    input  logic             hit_valid,
    input  logic [6:0]       hit_idx,
    output logic             hit_ack,
    output logic             hit_kill,
    output logic [9:0][5:0]  enemy_status,
    output logic [9:0]       fleet_x,
    output logic [8:0]       fleet_y,
    output logic             fleet_dir,
    output logic [5:0]       alive_count,
    output logic             anim_frame,
    output logic             wave_clear,
    output logic             fleet_landed
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLEAR, S_LANDED} state_t;

    state_t           state_q, state_d;
    logic [9:0][5:0]  grid_q, grid_d;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic             dir_q, dir_d;
    logic [5:0]       alive_q, alive_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             anim_q, anim_d;
    logic             ack_q, ack_d;
    logic             kill_q, kill_d;

    logic [3:0]  lcol, rcol;
    logic [2:0]  brow;
    logic [5:0]  row_any;
    logic [5:0]  period;
    logic [10:0] right_ext, left_ext, new_y, land_ext;
    logic [3:0]  hit_col;
    logic [2:0]  hit_row;
    logic        descend;

    assign hit_col = hit_idx[6:3];
    assign hit_row = hit_idx[2:0];

    // Extents of the live formation, taken from the registered grid.
    always_comb begin
        lcol    = '0;
        rcol    = '0;
        brow    = '0;
        row_any = '0;
        for (int c = 9; c >= 0; c--)
            if (|grid_q[c]) lcol = 4'(c);
        for (int c = 0; c <= 9; c++) begin
            if (|grid_q[c]) rcol = 4'(c);
            row_any = row_any | grid_q[c];
        end
        for (int r = 0; r <= 5; r++)
            if (row_any[r]) brow = 3'(r);
    end

    always_comb begin
        period    = 6'(PERIOD_MIN) + 6'(alive_q >> 2);
        right_ext = 11'(x_q) + 11'(rcol) * 11'(COL_PITCH) + 11'(ENEMY_W) + 11'(STEP_X);
        left_ext  = 11'(x_q) + 11'(lcol) * 11'(COL_PITCH);
        new_y     = 11'(y_q) + 11'(STEP_Y);
        land_ext  = new_y + 11'(brow) * 11'(ROW_PITCH) + 11'(ENEMY_H);
        descend   = dir_q ? (right_ext > 11'(X_MAX)) : (left_ext < 11'(X_MIN + STEP_X));
    end

    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        alive_d = alive_q;
        cnt_d   = cnt_q;
        anim_d  = anim_q;
        ack_d   = hit_valid;
        kill_d  = 1'b0;
        if (game_start) begin
            state_d = S_RUN;
            grid_d  = '1;
            x_d     = 10'(X_INIT);
            y_d     = 9'(Y_INIT);
            dir_d   = 1'b1;
            alive_d = 6'd60;
            cnt_d   = '0;
            anim_d  = 1'b0;
        end else if (state_q == S_RUN) begin
            if (frame_tick) begin
                if (cnt_q >= period - 6'd1) begin
                    cnt_d  = '0;
                    anim_d = ~anim_q;
                    if (descend) begin
                        y_d   = new_y[8:0];
                        dir_d = ~dir_q;
                        if (land_ext >= 11'(Y_LAND)) state_d = S_LANDED;
                    end else begin
                        x_d = dir_q ? x_q + 10'(STEP_X) : x_q - 10'(STEP_X);
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            // The last kill overrides a simultaneous landing.
            if (hit_valid && hit_col <= 4'd9 && hit_row <= 3'd5 && grid_q[hit_col][hit_row]) begin
                grid_d[hit_col][hit_row] = 1'b0;
                alive_d = alive_q - 6'd1;
                kill_d  = 1'b1;
                if (alive_q == 6'd1) state_d = S_CLEAR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grid_q  <= '1;
            x_q     <= 10'(X_INIT);
            y_q     <= 9'(Y_INIT);
            dir_q   <= 1'b1;
            alive_q <= 6'd60;
            cnt_q   <= '0;
            anim_q  <= 1'b0;
            ack_q   <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            alive_q <= alive_d;
            cnt_q   <= cnt_d;
            anim_q  <= anim_d;
            ack_q   <= ack_d;
            kill_q  <= kill_d;
        end
    end

    assign hit_ack      = ack_q;
    assign hit_kill     = kill_q;
    assign enemy_status = grid_q;
    assign fleet_x      = x_q;
    assign fleet_y      = y_q;
    assign fleet_dir    = dir_q;
    assign alive_count  = alive_q;
    assign anim_frame   = anim_q;
    assign wave_clear   = (state_q == S_CLEAR);
    assign fleet_landed = (state_q == S_LANDED);

endmodule

// File: tb/tb_enemy_fleet_ctrl.sv
// Directed bench for enemy_fleet_ctrl: hit vector table plus march,
// speed-up, wave-clear and landing sequences.
module tb_enemy_fleet_ctrl;

    logic             clk = 1'b0;
    logic             reset, frame_tick, game_start, hit_valid;
    logic [6:0]       hit_idx;
    logic             hit_ack, hit_kill;
    logic [9:0][5:0]  enemy_status;
    logic [9:0]       fleet_x;
    logic [8:0]       fleet_y;
    logic             fleet_dir;
    logic [5:0]       alive_count;
    logic             anim_frame, wave_clear, fleet_landed;

    int total = 0;
    int bad   = 0;

    enemy_fleet_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_start(game_start),
        .hit_valid(hit_valid), .hit_idx(hit_idx), .hit_ack(hit_ack), .hit_kill(hit_kill),
        .enemy_status(enemy_status), .fleet_x(fleet_x), .fleet_y(fleet_y),
        .fleet_dir(fleet_dir), .alive_count(alive_count), .anim_frame(anim_frame),
        .wave_clear(wave_clear), .fleet_landed(fleet_landed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       hv;
        logic [6:0] idx;
        logic       ack;
        logic       kill;
        logic [5:0] alive;
        logic [3:0] cc;
        logic [2:0] cr;
        logic       bit_e;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
        end
    endtask

    task automatic start();
        game_start = 1'b1;
        cyc();
        game_start = 1'b0;
    endtask

    initial begin
        logic [59:0] ones;
        logic [59:0] col9;
        logic [9:0]  px;
        logic [8:0]  py;
        int          kills, desc;

        ones = '1;
        col9 = {6'h3f, 54'd0};

        tbl[0] = '{1'b0, 1'b1, {4'd3, 3'd2}, 1'b1, 1'b0, 6'd60, 4'd3, 3'd2, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 7'd0,         1'b0, 1'b0, 6'd60, 4'd3, 3'd2, 1'b1};
        tbl[2] = '{1'b0, 1'b1, {4'd3, 3'd2}, 1'b1, 1'b1, 6'd59, 4'd3, 3'd2, 1'b0};
        tbl[3] = '{1'b0, 1'b1, {4'd3, 3'd2}, 1'b1, 1'b0, 6'd59, 4'd3, 3'd2, 1'b0};
        tbl[4] = '{1'b0, 1'b1, {4'd12, 3'd0}, 1'b1, 1'b0, 6'd59, 4'd3, 3'd2, 1'b0};
        tbl[5] = '{1'b0, 1'b1, {4'd0, 3'd6}, 1'b1, 1'b0, 6'd59, 4'd0, 3'd5, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 7'd0,         1'b0, 1'b0, 6'd59, 4'd0, 3'd0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, {4'd0, 3'd0}, 1'b1, 1'b0, 6'd60, 4'd3, 3'd2, 1'b1};
        tbl[8] = '{1'b0, 1'b1, {4'd9, 3'd5}, 1'b1, 1'b1, 6'd59, 4'd9, 3'd5, 1'b0};

        reset = 1'b1; frame_tick = 1'b0; game_start = 1'b0; hit_valid = 1'b0; hit_idx = '0;
        cyc(); cyc();
        reset = 1'b0;

        chk("rst_status", enemy_status, ones);
        chk("rst_x", fleet_x, 64);
        chk("rst_y", fleet_y, 48);
        chk("rst_dir", fleet_dir, 1);
        chk("rst_alive", alive_count, 60);
        chk("rst_ack", {hit_ack, hit_kill, anim_frame, wave_clear, fleet_landed}, 0);
        ticks(20);
        chk("idle_frozen_x", fleet_x, 64);

        for (int i = 0; i < 9; i++) begin
            game_start = tbl[i].start;
            hit_valid  = tbl[i].hv;
            hit_idx    = tbl[i].idx;
            cyc();
            game_start = 1'b0; hit_valid = 1'b0;
            chk($sformatf("v%0d_ack", i), hit_ack, tbl[i].ack);
            chk($sformatf("v%0d_kill", i), hit_kill, tbl[i].kill);
            chk($sformatf("v%0d_alive", i), alive_count, tbl[i].alive);
            chk($sformatf("v%0d_bit", i), enemy_status[tbl[i].cc][tbl[i].cr], tbl[i].bit_e);
        end

        // First step lands on the 17th tick of a full wave.
        start();
        ticks(16);
        chk("t16_x", fleet_x, 64);
        ticks(1);
        chk("t17_x", fleet_x, 68);
        chk("t17_anim", anim_frame, 1);
        chk("t17_alive", alive_count, 60);
        chk("t17_status", enemy_status, ones);

        // March right until the first descent.
        px = fleet_x;
        for (int i = 0; i < 2000 && fleet_y == 9'd48; i++) begin
            px = fleet_x;
            ticks(1);
        end
        chk("edge_last_x", px, 316);
        chk("edge_x", fleet_x, 316);
        chk("edge_y", fleet_y, 64);
        chk("edge_dir", fleet_dir, 0);
        chk("edge_anim", anim_frame, 0);
        ticks(17);
        chk("left_step_x", fleet_x, 312);

        // Kill columns 0-8: six alive gives a 3-frame period.
        start();
        kills = 0;
        for (int c = 0; c < 9; c++)
            for (int r = 0; r < 6; r++) begin
                hit_valid = 1'b1; hit_idx = {4'(c), 3'(r)};
                cyc();
                if (hit_ack && hit_kill) kills++;
            end
        hit_valid = 1'b0;
        chk("c08_kills", kills, 54);
        chk("c08_alive", alive_count, 6);
        chk("c08_status", enemy_status, col9);
        ticks(2);
        chk("p3_t2_x", fleet_x, 64);
        ticks(1);
        chk("p3_t3_x", fleet_x, 68);
        ticks(3);
        chk("p3_t6_x", fleet_x, 72);

        // Kill everything back to back; the first kill shares a cycle with a step.
        start();
        ticks(16);
        kills = 0;
        for (int i = 0; i < 60; i++) begin
            frame_tick = (i == 0);
            hit_valid  = 1'b1;
            hit_idx    = {4'(i / 6), 3'(i % 6)};
            cyc();
            frame_tick = 1'b0;
            if (hit_ack && hit_kill) kills++;
            if (i == 0) begin
                chk("hitstep_x", fleet_x, 68);
                chk("hitstep_alive", alive_count, 59);
            end
            if (i == 58) chk("clear_early", wave_clear, 0);
        end
        hit_valid = 1'b0;
        chk("clr_kills", kills, 60);
        chk("clr_alive", alive_count, 0);
        chk("clr_wave", wave_clear, 1);
        hit_valid = 1'b1; hit_idx = {4'd5, 3'd3};
        cyc();
        hit_valid = 1'b0;
        chk("clr_hit_ack", hit_ack, 1);
        chk("clr_hit_kill", hit_kill, 0);
        ticks(20);
        chk("clr_frozen_x", fleet_x, 68);
        start();
        chk("restart_alive", alive_count, 60);
        chk("restart_wave", wave_clear, 0);
        chk("restart_x", fleet_x, 64);

        // Landing: keep only [0][5] and [9][5] so extents match the full grid.
        kills = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 5 || i == 59) continue;
            hit_valid = 1'b1; hit_idx = {4'(i / 6), 3'(i % 6)};
            cyc();
            if (hit_kill) kills++;
        end
        hit_valid = 1'b0;
        chk("land_kills", kills, 58);
        chk("land_alive", alive_count, 2);
        desc = 0;
        py = fleet_y;
        for (int i = 0; i < 5000 && !fleet_landed; i++) begin
            ticks(1);
            if (fleet_y != py) begin
                desc++;
                py = fleet_y;
            end
        end
        chk("landed", fleet_landed, 1);
        chk("land_desc", desc, 16);
        chk("land_y", fleet_y, 304);
        chk("land_x", fleet_x, 8);
        ticks(10);
        chk("land_frozen_x", fleet_x, 8);
        chk("land_frozen_y", fleet_y, 304);
        chk("land_frozen_anim", anim_frame, 0);

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst2_landed", fleet_landed, 0);
        chk("rst2_x", fleet_x, 64);
        chk("rst2_y", fleet_y, 48);
        chk("rst2_alive", alive_count, 60);
        chk("rst2_status", enemy_status, ones);
        ticks(20);
        chk("rst2_idle_x", fleet_x, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
